// File: rtl/hazard_scheduler_if.sv
// hazard_scheduler_if
//   Bundles the ID/EX-side inputs and the pipeline-control outputs of the
//   hazard scheduler.
//   master : datapath side (drives ID fields and the EX branch result)
//   slave  : scheduler side (drives PC/IF-ID/ID-EX controls, state, counters)
//   Inputs : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
//            id_regwrite, ex_branch_taken
//   Outputs: pc_en, ifid_en, ifid_flush, idex_bubble, state, stall_cnt,
//            flush_cnt
interface hazard_scheduler_if;
   logic        id_valid;
   logic [5:0]  id_rs;
   logic [5:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic [5:0]  id_rd;
   logic        id_regwrite;
   logic        ex_branch_taken;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_bubble;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
             id_regwrite, ex_branch_taken,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, state, stall_cnt,
             flush_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
             id_regwrite, ex_branch_taken,
      output pc_en, ifid_en, ifid_flush, idex_bubble, state, stall_cnt,
             flush_cnt
   );
endinterface

// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Stall/flush controller for a 5-stage pipeline without forwarding.
//   A three-entry scoreboard tracks destination registers in EX, MEM, WB;
//   an ID instruction reading any of them is held (RAW stall), and a taken
//   EX branch flushes IF/ID and bubbles ID/EX.
//   i_clk : rising-edge clock
//   i_rst : synchronous active-high reset
//   bus   : hazard_scheduler_if.slave (ID fields in, pipeline controls out)
module hazard_scheduler (
   input  logic                  i_clk,
   input  logic                  i_rst,
   hazard_scheduler_if.slave     bus
);
   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_t;

   // scoreboard entries: index 0 = EX, 1 = MEM, 2 = WB
   logic [2:0]      r_sb_v;
   logic [2:0][5:0] r_sb_rd;
   state_t          r_state;
   logic [15:0]     r_stall_cnt;
   logic [15:0]     r_flush_cnt;

   logic [2:0] w_hit_rs;
   logic [2:0] w_hit_rt;
   logic       w_raw;
   logic       w_flush;
   logic       w_issue;

   // register 0 is tracked like any other register
   always_comb begin
      w_hit_rs = '0;
      w_hit_rt = '0;
      for (int i = 0; i < 3; i++) begin
         w_hit_rs[i] = r_sb_v[i] & (r_sb_rd[i] == bus.id_rs);
         w_hit_rt[i] = r_sb_v[i] & (r_sb_rd[i] == bus.id_rt);
      end
   end

   assign w_raw   = bus.id_valid & ((bus.id_uses_rs & (|w_hit_rs)) |
                                    (bus.id_uses_rt & (|w_hit_rt)));
   assign w_flush = bus.ex_branch_taken;
   assign w_issue = bus.id_valid & ~w_raw & ~w_flush;

   // Reset looks like a flush so the pipeline drains while held in reset.
   always_comb begin
      bus.pc_en       = 1'b1;
      bus.ifid_en     = 1'b1;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      if (i_rst || w_flush) begin
         bus.ifid_flush  = 1'b1;
         bus.idex_bubble = 1'b1;
      end else if (w_raw) begin
         bus.pc_en       = 1'b0;
         bus.ifid_en     = 1'b0;
         bus.idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sb_v      <= '0;
         r_sb_rd     <= '0;
         r_state     <= RUN;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_sb_v[2]  <= r_sb_v[1];
         r_sb_rd[2] <= r_sb_rd[1];
         r_sb_v[1]  <= r_sb_v[0];
         r_sb_rd[1] <= r_sb_rd[0];
         // stalled, flushed or empty ID slots enter EX as a bubble
         r_sb_v[0]  <= w_issue & bus.id_regwrite;
         r_sb_rd[0] <= w_issue ? bus.id_rd : 6'd0;

         if (w_flush)    r_state <= FLUSH;
         else if (w_raw) r_state <= STALL;
         else            r_state <= RUN;

         if (w_raw && !w_flush && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_flush && r_flush_cnt != 16'hFFFF)
            r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign bus.state     = r_state;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler
//   Directed scenarios plus randomized traffic against a timestamp-based
//   reference model: a write issued in cycle t blocks readers of its rd in
//   cycles t+1 .. t+3.
module tb_hazard_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   hazard_scheduler_if vif ();

   hazard_scheduler dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (vif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic [5:0] rd;
   } wr_t;

   wr_t         wq[$];
   int          cyc = 0;
   logic [1:0]  m_state = 2'b00;
   logic [15:0] m_stall = 16'd0;
   logic [15:0] m_flush = 16'd0;

   function automatic bit hit(input logic [5:0] r);
      foreach (wq[i])
         if (cyc - wq[i].t >= 1 && cyc - wq[i].t <= 3 && wq[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_raw();
      return vif.id_valid && ((vif.id_uses_rs && hit(vif.id_rs)) ||
                              (vif.id_uses_rt && hit(vif.id_rt)));
   endfunction

   // {pc_en, ifid_en, ifid_flush, idex_bubble}
   function automatic logic [3:0] m_ctl();
      if (rst || vif.ex_branch_taken) return 4'b1111;
      if (m_raw()) return 4'b0001;
      return 4'b1100;
   endfunction

   function automatic logic [37:0] exp_all();
      return {m_ctl(), m_state, m_stall, m_flush};
   endfunction

   function automatic logic [37:0] obs();
      return {vif.pc_en, vif.ifid_en, vif.ifid_flush, vif.idex_bubble,
              vif.state, vif.stall_cnt, vif.flush_cnt};
   endfunction

   // advance the model across the coming rising edge
   task automatic commit();
      bit r, f;
      r = m_raw();
      f = vif.ex_branch_taken;
      if (rst) begin
         wq.delete();
         m_state = 2'b00;
         m_stall = 16'd0;
         m_flush = 16'd0;
      end else begin
         m_state = f ? 2'b10 : (r ? 2'b01 : 2'b00);
         if (r && !f && m_stall != 16'hFFFF) m_stall++;
         if (f && m_flush != 16'hFFFF) m_flush++;
         if (vif.id_valid && !r && !f && vif.id_regwrite)
            wq.push_back('{cyc, vif.id_rd});
      end
      cyc++;
      while (wq.size() > 0 && cyc - wq[0].t > 3) void'(wq.pop_front());
   endtask

   task automatic drive(input bit r, input bit v, input logic [5:0] rs,
                        input logic [5:0] rt, input bit urs, input bit urt,
                        input logic [5:0] rd, input bit rw, input bit bt);
      @(negedge clk);
      rst                 = r;
      vif.id_valid        = v;
      vif.id_rs           = rs;
      vif.id_rt           = rt;
      vif.id_uses_rs      = urs;
      vif.id_uses_rt      = urt;
      vif.id_rd           = rd;
      vif.id_regwrite     = rw;
      vif.ex_branch_taken = bt;
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      commit();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      commit();
   endtask

   task automatic test_reset();
      drive(1, 1, 6'd3, 6'd3, 1, 1, 6'd3, 1, 0);
      if (obs() >> 34 !== 38'hF) begin
         bad++; $display("FAIL reset_ctl got=%b want=1111", obs() >> 34);
      end
      total++;
      commit();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      commit();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (obs() !== {4'b1100, 2'b00, 16'd0, 16'd0}) begin
         bad++; $display("FAIL reset_state got=%h want=%h", obs(), {4'b1100, 2'b00, 16'd0, 16'd0});
      end
      total++;
      commit();
   endtask

   task automatic test_raw_basic();
      int nstall = 0;
      do_reset();
      drive(0, 1, 6'd1, 6'd2, 0, 0, 6'd5, 1, 0);
      commit();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 6'd5, 6'd2, 1, 0, 6'd6, 0, 0);
         if (obs() !== exp_all()) begin
            bad++; $display("FAIL raw_basic k=%0d got=%h want=%h", k, obs(), exp_all());
         end
         total++;
         if (vif.pc_en === 1'b0) nstall++;
         commit();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (nstall != 3 || vif.stall_cnt !== 16'd3 || vif.state !== 2'b00) begin
         bad++; $display("FAIL raw_len stalls=%0d cnt=%0d state=%b want 3/3/00", nstall, vif.stall_cnt, vif.state);
      end
      total++;
      commit();
   endtask

   task automatic test_independent();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 6'(40 + i), 6'(50 + i), 1, 1, 6'(10 + i), 1, 0);
         if (obs() !== {4'b1100, 2'b00, 16'd0, 16'd0}) begin
            bad++; $display("FAIL indep i=%0d got=%h want=%h", i, obs(), {4'b1100, 2'b00, 16'd0, 16'd0});
         end
         total++;
         commit();
      end
   endtask

   task automatic test_flush();
      do_reset();
      drive(0, 1, 6'd1, 6'd2, 0, 0, 6'd7, 1, 1);
      if (obs() !== {4'b1111, 2'b00, 16'd0, 16'd0}) begin
         bad++; $display("FAIL flush_ctl got=%h want=%h", obs(), {4'b1111, 2'b00, 16'd0, 16'd0});
      end
      total++;
      commit();
      // the flushed write to r7 must not have entered EX
      drive(0, 1, 6'd7, 6'd7, 1, 1, 6'd8, 0, 0);
      if (obs() !== {4'b1100, 2'b10, 16'd0, 16'd1}) begin
         bad++; $display("FAIL flush_after got=%h want=%h", obs(), {4'b1100, 2'b10, 16'd0, 16'd1});
      end
      total++;
      commit();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (vif.state !== 2'b00) begin
         bad++; $display("FAIL flush_run got=%b want=00", vif.state);
      end
      total++;
      commit();
   endtask

   task automatic test_raw_flush();
      do_reset();
      drive(0, 1, 6'd1, 6'd2, 0, 0, 6'd9, 1, 0);
      commit();
      drive(0, 1, 6'd1, 6'd9, 0, 1, 6'd3, 1, 1);
      if (obs() !== {4'b1111, 2'b00, 16'd0, 16'd0}) begin
         bad++; $display("FAIL rawflush_ctl got=%h want=%h", obs(), {4'b1111, 2'b00, 16'd0, 16'd0});
      end
      total++;
      commit();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (obs() !== {4'b1100, 2'b10, 16'd0, 16'd1}) begin
         bad++; $display("FAIL rawflush_cnt got=%h want=%h", obs(), {4'b1100, 2'b10, 16'd0, 16'd1});
      end
      total++;
      commit();
   endtask

   task automatic test_unused_operand();
      do_reset();
      drive(0, 1, 6'd1, 6'd2, 0, 0, 6'd4, 1, 0);
      commit();
      drive(0, 1, 6'd4, 6'd3, 0, 1, 6'd5, 0, 0);
      if (obs() !== {4'b1100, 2'b00, 16'd0, 16'd0}) begin
         bad++; $display("FAIL uses_rs0 got=%h want=%h", obs(), {4'b1100, 2'b00, 16'd0, 16'd0});
      end
      total++;
      commit();
      drive(0, 0, 6'd4, 6'd4, 1, 1, 6'd5, 1, 0);
      if (obs() !== {4'b1100, 2'b00, 16'd0, 16'd0}) begin
         bad++; $display("FAIL invalid_id got=%h want=%h", obs(), {4'b1100, 2'b00, 16'd0, 16'd0});
      end
      total++;
      commit();
      // register 0 is hazard-tracked
      drive(0, 1, 6'd1, 6'd2, 0, 0, 6'd0, 1, 0);
      commit();
      drive(0, 1, 6'd0, 6'd2, 1, 0, 6'd1, 0, 0);
      if (obs() !== exp_all() || vif.pc_en !== 1'b0) begin
         bad++; $display("FAIL reg0_raw got=%h want=%h", obs(), exp_all());
      end
      total++;
      commit();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(0, 1, 6'd1, 6'd2, 0, 0, 6'd5, 1, 0);
      commit();
      drive(0, 1, 6'd5, 6'd2, 1, 0, 6'd6, 0, 0);
      commit();
      drive(1, 1, 6'd5, 6'd2, 1, 0, 6'd6, 0, 0);
      if (obs() >> 34 !== 38'hF) begin
         bad++; $display("FAIL midrst_ctl got=%b want=1111", obs() >> 34);
      end
      total++;
      commit();
      drive(0, 1, 6'd5, 6'd2, 1, 0, 6'd6, 0, 0);
      if (obs() !== {4'b1100, 2'b00, 16'd0, 16'd0}) begin
         bad++; $display("FAIL midrst_after got=%h want=%h", obs(), {4'b1100, 2'b00, 16'd0, 16'd0});
      end
      total++;
      commit();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 6'd1, 6'd2, 1, 1, 6'd3, 1, 1);
         if (obs() !== exp_all()) begin
            bad++; $display("FAIL b2b k=%0d got=%h want=%h", k, obs(), exp_all());
         end
         total++;
         commit();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (vif.flush_cnt !== 16'd2 || vif.state !== 2'b10) begin
         bad++; $display("FAIL b2b_cnt got=%0d/%b want=2/10", vif.flush_cnt, vif.state);
      end
      total++;
      commit();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 99) < 3, $urandom_range(0, 9) < 8,
               6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
               $urandom_range(0, 1), $urandom_range(0, 1),
               6'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 99) < 12);
         if (obs() !== exp_all()) begin
            bad++; $display("FAIL random n=%0d got=%h want=%h", n, obs(), exp_all());
         end
         total++;
         commit();
      end
   endtask

   initial begin
      test_reset();
      test_raw_basic();
      test_independent();
      test_flush();
      test_raw_flush();
      test_unused_operand();
      test_reset_mid_stall();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
